lb_dispatch_scheduler: RTL and testbench



---
 rtl/lb_pkg.sv | 18 +
 rtl/lb_min_select.sv | 28 ++
 rtl/priority_encoder_8to3.sv | 15 +
 rtl/lb_dispatch_scheduler.sv | 135 +++++++++++++
 tb/tb_lb_dispatch_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lb_pkg.sv
// Shared types and defaults for the load-balancer dispatch scheduler.
package lb_pkg;

  localparam int unsigned CNT_W_DFLT     = 4;
  localparam int unsigned THRESHOLD_DFLT = 3;
  localparam int unsigned MAX_LOAD_DFLT  = 15;

  localparam logic [1:0] SRV1 = 2'd0;
  localparam logic [1:0] SRV2 = 2'd1;
  localparam logic [1:0] SRV3 = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    STALL    = 2'd2
  } state_e;

endpackage

// File: rtl/lb_min_select.sv
// Picks the least-loaded of three servers; ties resolve to the lowest index.
module lb_min_select
  import lb_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DFLT
) (
  input  logic [CNT_W-1:0] load1,
  input  logic [CNT_W-1:0] load2,
  input  logic [CNT_W-1:0] load3,
  output logic [1:0]       min_idx,
  output logic [CNT_W-1:0] min_val
);

  always_comb begin
    min_idx = SRV1;
    min_val = load1;
    // Strict compares keep the earlier server on equal loads.
    if (load2 < min_val) begin
      min_idx = SRV2;
      min_val = load2;
    end
    if (load3 < min_val) begin
      min_idx = SRV3;
      min_val = load3;
    end
  end

endmodule

// File: rtl/priority_encoder_8to3.sv
// 8-to-3 priority encoder; bit 7 has the highest priority, all-zero input yields 0.
module priority_encoder_8to3 (
  input  logic [7:0] req,
  output logic [2:0] idx
);

  always_comb begin
    idx = 3'd0;
    // Ascending scan so the highest set bit is the last to win.
    for (int i = 0; i < 8; i++) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/lb_dispatch_scheduler.sv
// Load-balancer dispatch scheduler: drains a task batch in priority order onto
// the least-loaded of three servers, tracking per-server outstanding load.
module lb_dispatch_scheduler
  import lb_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DFLT,
  parameter int unsigned THRESHOLD = THRESHOLD_DFLT,
  parameter int unsigned MAX_LOAD  = MAX_LOAD_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             batch_valid,
  input  logic [7:0]       batch_tasks,
  output logic             batch_ready,
  input  logic [2:0]       done,
  output logic             dispatch_valid,
  output logic [1:0]       dispatch_server,
  output logic [2:0]       dispatch_task,
  output logic [CNT_W-1:0] server1_count,
  output logic [CNT_W-1:0] server2_count,
  output logic [CNT_W-1:0] server3_count,
  output logic             trigger,
  output logic             overload,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LOAD);
  localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESHOLD);

  state_e           state_q, state_d;
  logic [7:0]       pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [CNT_W-1:0] post_done [3];
  logic             dv_q, dv_d;
  logic [1:0]       ds_q, ds_d;
  logic [2:0]       dt_q, dt_d;
  logic [2:0]       inc;

  logic [2:0]       task_idx;
  logic [1:0]       min_idx;
  logic [CNT_W-1:0] min_val;

  priority_encoder_8to3 u_prio (
    .req (pending_q),
    .idx (task_idx)
  );

  lb_min_select #(.CNT_W(CNT_W)) u_min (
    .load1   (cnt_q[0]),
    .load2   (cnt_q[1]),
    .load3   (cnt_q[2]),
    .min_idx (min_idx),
    .min_val (min_val)
  );

  // Completions applied first; a completion at zero load is dropped.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      post_done[i] = cnt_q[i];
      if (done[i] && (cnt_q[i] != '0)) post_done[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = post_done[i] + CNT_W'(inc[i]);
    end
  end

  // Next-state and dispatch decision.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dv_d      = 1'b0;
    ds_d      = ds_q;
    dt_d      = dt_q;
    inc       = 3'b000;
    case (state_q)
      IDLE: begin
        if (batch_valid && (batch_tasks != 8'h00)) begin
          pending_d = batch_tasks;
          state_d   = DISPATCH;
        end
      end
      DISPATCH: begin
        if (min_val < MAX_C) begin
          pending_d = pending_q & ~(8'(1) << task_idx);
          inc       = 3'(1) << min_idx;
          dv_d      = 1'b1;
          ds_d      = min_idx;
          dt_d      = task_idx;
          if (pending_d == 8'h00) state_d = IDLE;
        end else begin
          state_d = STALL;
        end
      end
      STALL: begin
        if ((post_done[0] < MAX_C) || (post_done[1] < MAX_C) || (post_done[2] < MAX_C))
          state_d = DISPATCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      dv_q      <= 1'b0;
      ds_q      <= 2'd0;
      dt_q      <= 3'd0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dv_q      <= dv_d;
      ds_q      <= ds_d;
      dt_q      <= dt_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign batch_ready     = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign dispatch_valid  = dv_q;
  assign dispatch_server = ds_q;
  assign dispatch_task   = dt_q;
  assign server1_count   = cnt_q[0];
  assign server2_count   = cnt_q[1];
  assign server3_count   = cnt_q[2];
  assign trigger  = (cnt_q[0] >= THR_C) || (cnt_q[1] >= THR_C) || (cnt_q[2] >= THR_C);
  assign overload = (cnt_q[0] >= THR_C) && (cnt_q[1] >= THR_C) && (cnt_q[2] >= THR_C);

endmodule

// File: tb/tb_lb_dispatch_scheduler.sv
// Directed bench for lb_dispatch_scheduler with a dispatch scoreboard per instance.
module tb_lb_dispatch_scheduler;

  typedef struct packed {
    logic [1:0] srv;
    logic [2:0] tsk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       rst_a, bv_a, br_a, dv_a, trig_a, ovl_a, busy_a;
  logic [7:0] bt_a;
  logic [2:0] done_a, dt_a;
  logic [1:0] ds_a;
  logic [3:0] c1_a, c2_a, c3_a;

  // Instance B: MAX_LOAD = 2 to reach the stall condition quickly
  logic       rst_b, bv_b, br_b, dv_b, trig_b, ovl_b, busy_b;
  logic [7:0] bt_b;
  logic [2:0] done_b, dt_b;
  logic [1:0] ds_b;
  logic [3:0] c1_b, c2_b, c3_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_err = 0;

  lb_dispatch_scheduler u_dut_a (
    .clk(clk), .reset(rst_a), .batch_valid(bv_a), .batch_tasks(bt_a), .batch_ready(br_a),
    .done(done_a), .dispatch_valid(dv_a), .dispatch_server(ds_a), .dispatch_task(dt_a),
    .server1_count(c1_a), .server2_count(c2_a), .server3_count(c3_a),
    .trigger(trig_a), .overload(ovl_a), .busy(busy_a)
  );

  lb_dispatch_scheduler #(.MAX_LOAD(2)) u_dut_b (
    .clk(clk), .reset(rst_b), .batch_valid(bv_b), .batch_tasks(bt_b), .batch_ready(br_b),
    .done(done_b), .dispatch_valid(dv_b), .dispatch_server(ds_b), .dispatch_task(dt_b),
    .server1_count(c1_b), .server2_count(c2_b), .server3_count(c3_b),
    .trigger(trig_b), .overload(ovl_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pops on every dispatch pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (dv_a === 1'b1) begin
      chk("a_sb_has_entry", 32'(q_a.size() > 0), 32'd1);
      if (q_a.size() > 0) begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_dispatch_server", 32'(ds_a), 32'(e.srv));
        chk("a_dispatch_task", 32'(dt_a), 32'(e.tsk));
      end
    end
    if (dv_b === 1'b1) begin
      chk("b_sb_has_entry", 32'(q_b.size() > 0), 32'd1);
      if (q_b.size() > 0) begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_dispatch_server", 32'(ds_b), 32'(e.srv));
        chk("b_dispatch_task", 32'(dt_b), 32'(e.tsk));
      end
    end
  end

  initial begin
    rst_a = 1'b1; bv_a = 1'b0; bt_a = 8'h00; done_a = 3'b000;
    rst_b = 1'b1; bv_b = 1'b0; bt_b = 8'h00; done_b = 3'b000;
    step();
    step();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    chk("rst_counts", 32'({c1_a, c2_a, c3_a}), 32'h000);
    chk("rst_ready", 32'(br_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_dv", 32'(dv_a), 32'd0);
    chk("rst_ds_dt", 32'({ds_a, dt_a}), 32'd0);
    chk("rst_trigger", 32'(trig_a), 32'd0);

    // Test 1: batch 1000_0001
    bt_a = 8'h81; bv_a = 1'b1;
    q_a.push_back('{srv: 2'd0, tsk: 3'd7});
    q_a.push_back('{srv: 2'd1, tsk: 3'd0});
    step();
    bv_a = 1'b0;
    chk("t1_busy_after_accept", 32'(busy_a), 32'd1);
    chk("t1_ready_after_accept", 32'(br_a), 32'd0);
    chk("t1_no_dv_at_accept", 32'(dv_a), 32'd0);
    step();
    chk("t1_dv1", 32'(dv_a), 32'd1);
    chk("t1_ready_mid", 32'(br_a), 32'd0);
    step();
    chk("t1_dv2", 32'(dv_a), 32'd1);
    chk("t1_ready_with_last", 32'(br_a), 32'd1);
    chk("t1_counts", 32'({c1_a, c2_a, c3_a}), 32'h110);
    step();
    chk("t1_dv_idle", 32'(dv_a), 32'd0);
    chk("t1_hold_task", 32'(dt_a), 32'd0);

    // Test 2: 8'hFF round-robins through equal loads
    rst_a = 1'b1; step(); rst_a = 1'b0;
    chk("t2_counts_rst", 32'({c1_a, c2_a, c3_a}), 32'h000);
    bt_a = 8'hFF; bv_a = 1'b1;
    for (int i = 0; i < 8; i++) q_a.push_back('{srv: 2'(i % 3), tsk: 3'(7 - i)});
    step();
    bv_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_dv_consecutive", 32'(dv_a), 32'd1);
    end
    chk("t2_ready", 32'(br_a), 32'd1);
    chk("t2_counts", 32'({c1_a, c2_a, c3_a}), 32'h332);
    chk("t2_trigger", 32'(trig_a), 32'd1);
    chk("t2_overload", 32'(ovl_a), 32'd0);

    // Test 3: single task lands on the lightest server
    bt_a = 8'h01; bv_a = 1'b1;
    q_a.push_back('{srv: 2'd2, tsk: 3'd0});
    step();
    bv_a = 1'b0;
    step();
    chk("t3_dv", 32'(dv_a), 32'd1);
    chk("t3_counts", 32'({c1_a, c2_a, c3_a}), 32'h333);
    chk("t3_overload", 32'(ovl_a), 32'd1);

    // Test 5: dispatch coincident with done, and done at zero load
    rst_a = 1'b1; step(); rst_a = 1'b0;
    bt_a = 8'hE0; bv_a = 1'b1;
    q_a.push_back('{srv: 2'd0, tsk: 3'd7});
    q_a.push_back('{srv: 2'd1, tsk: 3'd6});
    q_a.push_back('{srv: 2'd2, tsk: 3'd5});
    step();
    bv_a = 1'b0;
    step(); step(); step();
    chk("t5_counts_pre", 32'({c1_a, c2_a, c3_a}), 32'h111);
    bt_a = 8'h01; bv_a = 1'b1;
    q_a.push_back('{srv: 2'd0, tsk: 3'd0});
    step();
    bv_a = 1'b0;
    done_a = 3'b001;
    step();
    done_a = 3'b000;
    chk("t5_dv_with_done", 32'(dv_a), 32'd1);
    chk("t5_counts_unchanged", 32'({c1_a, c2_a, c3_a}), 32'h111);
    done_a = 3'b100;
    step();
    chk("t5_c3_dec", 32'(c3_a), 32'd0);
    step();
    done_a = 3'b000;
    chk("t5_c3_no_wrap", 32'(c3_a), 32'd0);

    // Test 6: reset mid-batch discards pending work
    rst_a = 1'b1; step(); rst_a = 1'b0;
    bt_a = 8'hFF; bv_a = 1'b1;
    q_a.push_back('{srv: 2'd0, tsk: 3'd7});
    q_a.push_back('{srv: 2'd1, tsk: 3'd6});
    step();
    bv_a = 1'b0;
    step(); step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("t6_counts", 32'({c1_a, c2_a, c3_a}), 32'h000);
    chk("t6_ready", 32'(br_a), 32'd1);
    chk("t6_busy", 32'(busy_a), 32'd0);
    chk("t6_dv", 32'(dv_a), 32'd0);
    chk("t6_ds_dt", 32'({ds_a, dt_a}), 32'd0);
    step();
    chk("t6_dv_after", 32'(dv_a), 32'd0);
    bt_a = 8'h00; bv_a = 1'b1;
    step();
    bv_a = 1'b0;
    chk("t6_empty_batch_busy", 32'(busy_a), 32'd0);
    chk("t6_empty_batch_ready", 32'(br_a), 32'd1);
    step();
    chk("t6_empty_batch_dv", 32'(dv_a), 32'd0);

    // Test 4: stall at MAX_LOAD=2, released by a completion
    bt_b = 8'h7F; bv_b = 1'b1;
    for (int i = 0; i < 6; i++) q_b.push_back('{srv: 2'(i % 3), tsk: 3'(6 - i)});
    q_b.push_back('{srv: 2'd1, tsk: 3'd0});
    step();
    bv_b = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t4_counts_full", 32'({c1_b, c2_b, c3_b}), 32'h222);
    step();
    chk("t4_stall_busy", 32'(busy_b), 32'd1);
    chk("t4_stall_no_dv", 32'(dv_b), 32'd0);
    step();
    chk("t4_stall_hold_dv", 32'(dv_b), 32'd0);
    chk("t4_stall_ready", 32'(br_b), 32'd0);
    done_b = 3'b010;
    step();
    done_b = 3'b000;
    chk("t4_c2_released", 32'(c2_b), 32'd1);
    chk("t4_no_dv_on_release", 32'(dv_b), 32'd0);
    step();
    chk("t4_dv_after_stall", 32'(dv_b), 32'd1);
    chk("t4_counts_final", 32'({c1_b, c2_b, c3_b}), 32'h222);
    chk("t4_ready_final", 32'(br_b), 32'd1);
    step();

    chk("a_sb_drained", 32'(q_a.size()), 32'd0);
    chk("b_sb_drained", 32'(q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
